// File: rtl/riscv_pkg.sv
// Shared RISC-V load/store encodings, LSU FSM state type and byte-lane helpers.
package riscv_pkg;

  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_HALF   = 3'b001;
  localparam logic [2:0] F3_WORD   = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [2:0] F3_HALF_U = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT,
    LSU_DONE
  } lsu_state_t;

  // Reserved encodings fall through to the word case everywhere below.
  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_BYTE, F3_BYTE_U: return 4'b0001 << off;
      F3_HALF, F3_HALF_U: return 4'b0011 << {off[1], 1'b0};
      default:            return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wdata);
    case (f3)
      F3_BYTE, F3_BYTE_U: return {4{wdata[7:0]}};
      F3_HALF, F3_HALF_U: return {2{wdata[15:0]}};
      F3_WORD:            return wdata;
      default:            return wdata;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_BYTE, F3_BYTE_U: return 1'b0;
      F3_HALF, F3_HALF_U: return off[0];
      default:            return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the LSU (master) and RAM/MMIO (slave).
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic        mem_mmio;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  // mem_req is held with stable payload until mem_gnt; mem_rvalid may
  // coincide with mem_gnt or arrive in any later cycle.
  modport master (
    output mem_req, mem_we, mem_mmio, mem_be, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_mmio, mem_be, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed byte/half of a bus word and sign- or zero-extends it.
module lsu_load_align
  import riscv_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] byte_lane;
    logic [31:0] half_lane;

    always_comb begin
        byte_lane = mem_rdata >> {offset, 3'b000};
        half_lane = mem_rdata >> {offset[1], 4'b0000};
        case (funct3)
            F3_BYTE:   result = {{24{byte_lane[7]}}, byte_lane[7:0]};
            F3_BYTE_U: result = {24'h0, byte_lane[7:0]};
            F3_HALF:   result = {{16{half_lane[15]}}, half_lane[15:0]};
            F3_HALF_U: result = {16'h0, half_lane[15:0]};
            default:   result = mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for the data-memory bus.
// Build option: LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of issuing them.
module load_store_unit
  import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] MMIO_BASE      = 32'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     lsu_valid,
    output logic                     lsu_ready,
    input  logic                     lsu_we,
    input  logic [2:0]               lsu_funct3,
    input  logic [31:0]              lsu_addr,
    input  logic [31:0]              lsu_wdata,
    output logic [31:0]              lsu_rdata,
    output logic                     lsu_done,
    output logic                     lsu_err,
    load_store_unit_if.master        mem,
    output lsu_state_t               lsu_state
);

    lsu_state_t  state_q, state_d;
    logic        accept, misalign, granted, capture, timeout_hit, abort;
    logic        we_q, err_q, mmio_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, wdata_q, rdata_q, cnt_q, load_val;

    lsu_load_align u_load_align (
        .mem_rdata (mem.mem_rdata),
        .offset    (off_q),
        .funct3    (funct3_q),
        .result    (load_val)
    );

    always_comb begin
        state_d     = state_q;
        abort       = 1'b0;
        accept      = lsu_valid && (state_q == LSU_IDLE);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign    = is_misaligned(lsu_funct3, lsu_addr[1:0]);
`else
        misalign    = 1'b0;
`endif
        granted     = (state_q == LSU_REQ) && mem.mem_gnt;
        // Read data counts only once the request has been granted.
        capture     = !we_q && mem.mem_rvalid && (granted || (state_q == LSU_WAIT));
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);
        case (state_q)
            LSU_IDLE: if (accept) state_d = misalign ? LSU_DONE : LSU_REQ;
            LSU_REQ: begin
                if (granted) begin
                    state_d = (we_q || capture) ? LSU_DONE : LSU_WAIT;
                end else if (timeout_hit) begin
                    state_d = LSU_DONE;
                    abort   = 1'b1;
                end
            end
            LSU_WAIT: begin
                if (capture) begin
                    state_d = LSU_DONE;
                end else if (timeout_hit) begin
                    state_d = LSU_DONE;
                    abort   = 1'b1;
                end
            end
            LSU_DONE: state_d = LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= LSU_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            off_q    <= 2'b00;
            addr_q   <= 32'h0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            mmio_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
            cnt_q    <= 32'h0;
        end else begin
            if (accept) begin
                we_q     <= lsu_we;
                funct3_q <= lsu_funct3;
                off_q    <= lsu_addr[1:0];
                addr_q   <= {lsu_addr[31:2], 2'b00};
                be_q     <= byte_enable(lsu_funct3, lsu_addr[1:0]);
                wdata_q  <= lsu_we ? store_data(lsu_funct3, lsu_wdata) : 32'h0;
                mmio_q   <= (lsu_addr >= MMIO_BASE);
                err_q    <= misalign;
                cnt_q    <= 32'h0;
                if (misalign) rdata_q <= lsu_addr;
            end else if ((state_q == LSU_REQ) || (state_q == LSU_WAIT)) begin
                cnt_q <= cnt_q + 32'd1;
            end
            if (capture) rdata_q <= load_val;
            if (abort) begin
                err_q   <= 1'b1;
                rdata_q <= 32'h0;
            end
            if (state_q == LSU_DONE) err_q <= 1'b0;
        end
    end

    // mem_req is decoded from state so an asynchronous reset drops it at once.
    assign mem.mem_req   = (state_q == LSU_REQ);
    assign mem.mem_we    = (state_q == LSU_REQ) && we_q;
    assign mem.mem_mmio  = mmio_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign lsu_ready     = (state_q == LSU_IDLE);
    assign lsu_done      = (state_q == LSU_DONE);
    assign lsu_err       = (state_q == LSU_DONE) && err_q;
    assign lsu_rdata     = rdata_q;
    assign lsu_state     = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, scoreboard of load results,
// hand-written timeout, reset and misalign sequences.
module tb_load_store_unit;
  import riscv_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lsu_valid = 1'b0;
  logic        lsu_ready;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_funct3 = 3'b000;
  logic [31:0] lsu_addr = 32'h0;
  logic [31:0] lsu_wdata = 32'h0;
  logic [31:0] lsu_rdata;
  logic        lsu_done;
  logic        lsu_err;
  lsu_state_t  lsu_state;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  load_store_unit_if bus ();
  assign bus.mem_gnt    = mem_gnt;
  assign bus.mem_rvalid = mem_rvalid;
  assign bus.mem_rdata  = mem_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .MMIO_BASE(32'h8000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_we     (lsu_we),
    .lsu_funct3 (lsu_funct3),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_rdata  (lsu_rdata),
    .lsu_done   (lsu_done),
    .lsu_err    (lsu_err),
    .mem        (bus),
    .lsu_state  (lsu_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus_rdata;
    int          g;
    int          r;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic        mmio;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] bus_rdata,
                              input int g, input int r, input logic [3:0] be,
                              input logic [31:0] maddr, input logic [31:0] mwdata,
                              input logic mmio, input logic [31:0] rdata);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.bus_rdata = bus_rdata;
    v.g = g; v.r = r; v.be = be; v.maddr = maddr; v.mwdata = mwdata; v.mmio = mmio;
    v.rdata = rdata;
    return v;
  endfunction

  // driver: called #1 after a rising edge with the DUT idle
  task automatic run_access(input vec_t v);
    int  exp_done;
    bit  done_seen;
    logic [31:0] exp_r;
    lsu_valid  = 1'b1;
    lsu_we     = v.we;
    lsu_funct3 = v.f3;
    lsu_addr   = v.addr;
    lsu_wdata  = v.wdata;
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    exp_q.push_back(v.rdata);
    exp_done  = v.g + 1 + (v.we ? 0 : v.r);
    done_seen = 1'b0;
    for (int c = 0; c < 40 && !done_seen; c++) begin
      check("mem_req", 32'(bus.mem_req), 32'(c <= v.g));
      if (c <= v.g) begin
        check("mem_be", 32'(bus.mem_be), 32'(v.be));
        check("mem_addr", bus.mem_addr, v.maddr);
        check("mem_wdata", bus.mem_wdata, v.mwdata);
        check("mem_mmio", 32'(bus.mem_mmio), 32'(v.mmio));
        check("mem_we", 32'(bus.mem_we), 32'(v.we));
      end
      if (lsu_done) begin
        done_seen = 1'b1;
        check("done_cycle", 32'(c), 32'(exp_done));
        check("lsu_err", 32'(lsu_err), 32'(0));
        if (exp_q.size() == 0) begin
          check("sb_nonempty", 32'(0), 32'(1));
        end else begin
          exp_r = exp_q.pop_front();
          if (!v.we) check("lsu_rdata", lsu_rdata, exp_r);
        end
      end else begin
        check("ready_busy", 32'(lsu_ready), 32'(0));
        mem_gnt    = (c == v.g);
        // early rvalid before the grant carries junk and must be ignored
        mem_rvalid = !v.we && ((c == v.g + v.r) || (c < v.g));
        mem_rdata  = (c == v.g + v.r) ? v.bus_rdata : 32'h5A5A_5A5A;
        @(posedge clk); #1;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
      end
    end
    if (!done_seen) check("done_timeout", 32'(0), 32'(1));
    @(posedge clk); #1;
    check("done_pulse_end", 32'(lsu_done), 32'(0));
    check("ready_after", 32'(lsu_ready), 32'(1));
  endtask

  task automatic timeout_access(input bit gnt_first);
    bit done_seen;
    lsu_valid  = 1'b1;
    lsu_we     = 1'b0;
    lsu_funct3 = F3_WORD;
    lsu_addr   = 32'h0000_0300;
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    exp_q.push_back(32'h0);
    mem_rdata = 32'hFFFF_FFFF;
    done_seen = 1'b0;
    for (int c = 0; c < 30 && !done_seen; c++) begin
      if (lsu_done) begin
        done_seen = 1'b1;
        check("to_err", 32'(lsu_err), 32'(1));
        check("to_rdata", lsu_rdata, exp_q.pop_front());
        check("to_cycle", 32'((c >= TO) && (c <= TO + 1)), 32'(1));
        check("to_req_low", 32'(bus.mem_req), 32'(0));
      end else begin
        mem_gnt = gnt_first && (c == 0);
        @(posedge clk); #1;
        mem_gnt = 1'b0;
      end
    end
    if (!done_seen) check("to_done_seen", 32'(0), 32'(1));
    @(posedge clk); #1;
    check("to_idle", 32'(lsu_state), 32'(LSU_IDLE));
    check("to_err_end", 32'(lsu_err), 32'(0));
  endtask

  // reset while an access is outstanding; wait_state selects WAIT, else REQ
  task automatic reset_mid_access(input bit wait_state);
    lsu_valid  = 1'b1;
    lsu_we     = 1'b0;
    lsu_funct3 = F3_WORD;
    lsu_addr   = 32'h0000_0400;
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    check("rst_req_up", 32'(bus.mem_req), 32'(1));
    if (wait_state) begin
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      check("rst_in_wait", 32'(lsu_state), 32'(LSU_WAIT));
    end
    #2 rst = 1'b1;
    #1;
    check("rst_req_drop", 32'(bus.mem_req), 32'(0));
    check("rst_state", 32'(lsu_state), 32'(LSU_IDLE));
    check("rst_done", 32'(lsu_done), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mem_rvalid = (c == 0);
      mem_rdata  = 32'h1357_9BDF;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      check("rst_no_done", 32'(lsu_done), 32'(0));
    end
    check("rst_ready", 32'(lsu_ready), 32'(1));
  endtask

`ifdef LSU_MISALIGN_TRAP_EN
  task automatic trap_access(input logic [2:0] f3, input logic [31:0] addr);
    lsu_valid  = 1'b1;
    lsu_we     = 1'b0;
    lsu_funct3 = f3;
    lsu_addr   = addr;
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    check("trap_no_req", 32'(bus.mem_req), 32'(0));
    check("trap_done", 32'(lsu_done), 32'(1));
    check("trap_err", 32'(lsu_err), 32'(1));
    check("trap_rdata", lsu_rdata, addr);
    @(posedge clk); #1;
    check("trap_done_end", 32'(lsu_done), 32'(0));
    check("trap_ready", 32'(lsu_ready), 32'(1));
  endtask
`endif

  initial begin
    //          we  f3         addr          wdata         bus           g  r  be       maddr         mwdata        mmio  rdata
    vecs.push_back(mk(1, F3_BYTE,   32'h0000_0013, 32'h1234_56AB, 32'h0,         0, 0, 4'b1000, 32'h0000_0010, 32'hABAB_ABAB, 0, 32'h0));
    vecs.push_back(mk(0, F3_BYTE,   32'h0000_0021, 32'h0,         32'h0000_8000, 0, 1, 4'b0010, 32'h0000_0020, 32'h0,         0, 32'hFFFF_FF80));
    vecs.push_back(mk(0, F3_BYTE_U, 32'h0000_0021, 32'h0,         32'h0000_8000, 0, 0, 4'b0010, 32'h0000_0020, 32'h0,         0, 32'h0000_0080));
    vecs.push_back(mk(0, F3_HALF,   32'h0000_0042, 32'h0,         32'hBEEF_1234, 3, 1, 4'b1100, 32'h0000_0040, 32'h0,         0, 32'hFFFF_BEEF));
    vecs.push_back(mk(1, F3_WORD,   32'h8000_0000, 32'h0000_0005, 32'h0,         0, 0, 4'b1111, 32'h8000_0000, 32'h0000_0005, 1, 32'h0));
    vecs.push_back(mk(0, F3_WORD,   32'h8000_0004, 32'h0,         32'hCAFE_F00D, 1, 0, 4'b1111, 32'h8000_0004, 32'h0,         1, 32'hCAFE_F00D));
    vecs.push_back(mk(0, F3_HALF_U, 32'h0000_0102, 32'h0,         32'h8001_7FFF, 0, 1, 4'b1100, 32'h0000_0100, 32'h0,         0, 32'h0000_8001));
    vecs.push_back(mk(1, F3_HALF,   32'h0000_000A, 32'hDEAD_BEEF, 32'h0,         2, 0, 4'b1100, 32'h0000_0008, 32'hBEEF_BEEF, 0, 32'h0));
    vecs.push_back(mk(0, F3_BYTE,   32'h0000_0003, 32'h0,         32'h7F00_0000, 0, 2, 4'b1000, 32'h0000_0000, 32'h0,         0, 32'h0000_007F));
    vecs.push_back(mk(0, 3'b011,    32'h0000_0204, 32'h0,         32'h1122_3344, 0, 0, 4'b1111, 32'h0000_0204, 32'h0,         0, 32'h1122_3344));
    vecs.push_back(mk(1, F3_BYTE,   32'h7FFF_FFFF, 32'h0000_00C3, 32'h0,         1, 0, 4'b1000, 32'h7FFF_FFFC, 32'hC3C3_C3C3, 0, 32'h0));
    vecs.push_back(mk(0, F3_HALF,   32'h0000_0010, 32'h0,         32'h0000_00FF, 0, 0, 4'b0011, 32'h0000_0010, 32'h0,         0, 32'h0000_00FF));
`ifndef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk(0, F3_HALF,   32'h0000_0043, 32'h0,         32'h80FF_0000, 0, 0, 4'b1100, 32'h0000_0040, 32'h0,         0, 32'hFFFF_80FF));
    vecs.push_back(mk(1, F3_WORD,   32'h0000_0007, 32'h0102_0304, 32'h0,         0, 0, 4'b1111, 32'h0000_0004, 32'h0102_0304, 0, 32'h0));
    vecs.push_back(mk(0, 3'b110,    32'h0000_0006, 32'h0,         32'hA5A5_0F0F, 0, 0, 4'b1111, 32'h0000_0004, 32'h0,         0, 32'hA5A5_0F0F));
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready_init", 32'(lsu_ready), 32'(1));
    check("rst_done_init", 32'(lsu_done), 32'(0));
    check("rst_err_init", 32'(lsu_err), 32'(0));
    check("rst_req_init", 32'(bus.mem_req), 32'(0));
    check("rst_we_init", 32'(bus.mem_we), 32'(0));
    check("rst_mmio_init", 32'(bus.mem_mmio), 32'(0));
    check("rst_be_init", 32'(bus.mem_be), 32'(0));
    check("rst_addr_init", bus.mem_addr, 32'h0);
    check("rst_wdata_init", bus.mem_wdata, 32'h0);
    check("rst_rdata_init", lsu_rdata, 32'h0);
    check("rst_state_init", 32'(lsu_state), 32'(LSU_IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) run_access(vecs[i]);

    timeout_access(1'b0);
    timeout_access(1'b1);

    reset_mid_access(1'b1);
    run_access(vecs[1]);
    reset_mid_access(1'b0);
    run_access(vecs[3]);

`ifdef LSU_MISALIGN_TRAP_EN
    trap_access(F3_WORD, 32'h0000_0102);
    trap_access(F3_HALF_U, 32'h0000_0041);
    run_access(vecs[5]);
`endif

    check("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
